// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Results are computed at accept and land when the busy countdown expires.
module mdu_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       MDUOp,
  input  logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                        MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MUL_LAT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LAT = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] ONE     = CW'(1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] phi_q, phi_d;
  logic [WIDTH-1:0] plo_q, plo_d;
  logic             pwr_q, pwr_d;

  logic               sgn, a_neg, b_neg;
  logic               is_mul, is_div;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic [WIDTH-1:0]   a_mag, b_mag, b_safe;
  logic [WIDTH-1:0]   uq, ur, quo, rem;

  assign busy = (cnt_q != '0);
  assign HI   = hi_q;
  assign LO   = lo_q;

  always_comb begin
    sgn    = (MDUOp == OP_MULT) || (MDUOp == OP_DIV);
    is_mul = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
    is_div = (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);
    a_neg  = sgn & A[WIDTH-1];
    b_neg  = sgn & B[WIDTH-1];
    a_ext  = {{WIDTH{a_neg}}, A};
    b_ext  = {{WIDTH{b_neg}}, B};
    prod   = a_ext * b_ext;
    // Signed divide on magnitudes; the most-negative / -1 case
    // wraps back to A with a zero remainder on its own.
    a_mag  = a_neg ? -A : A;
    b_mag  = b_neg ? -B : B;
    b_safe = (B == '0) ? WIDTH'(1) : b_mag;
    uq     = a_mag / b_safe;
    ur     = a_mag % b_safe;
    quo    = (a_neg ^ b_neg) ? -uq : uq;
    rem    = a_neg ? -ur : ur;
  end

  always_comb begin
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    phi_d = phi_q;
    plo_d = plo_q;
    pwr_d = pwr_q;
    if (busy) begin
      cnt_d = cnt_q - ONE;
      if (cnt_q == ONE && pwr_q) begin
        hi_d = phi_q;
        lo_d = plo_q;
      end
    end else if (start) begin
      unique case (1'b1)
        is_mul: begin
          cnt_d = MUL_LAT;
          phi_d = prod[2*WIDTH-1:WIDTH];
          plo_d = prod[WIDTH-1:0];
          pwr_d = 1'b1;
        end
        is_div: begin
          cnt_d = DIV_LAT;
          phi_d = rem;
          plo_d = quo;
          pwr_d = (B != '0);
        end
        (MDUOp == OP_MTHI): hi_d = A;
        (MDUOp == OP_MTLO): lo_d = A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      phi_q <= '0;
      plo_q <= '0;
      pwr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      phi_q <= phi_d;
      plo_q <= plo_d;
      pwr_q <= pwr_d;
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: 32-bit default instance plus a
// 16-bit, single-cycle-multiply instance.
module tb_mdu_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] a, b, hi, lo;
  logic [2:0]  op;
  logic        start, busy;
  logic [15:0] a16, b16, hi16, lo16;
  logic [2:0]  op16;
  logic        start16, busy16;

  mdu_unit dut (
    .clk(clk), .reset(reset), .A(a), .B(b), .MDUOp(op),
    .start(start), .busy(busy), .HI(hi), .LO(lo)
  );

  mdu_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut16 (
    .clk(clk), .reset(reset), .A(a16), .B(b16), .MDUOp(op16),
    .start(start16), .busy(busy16), .HI(hi16), .LO(lo16)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    bit          rst;
  } exp_t;

  exp_t sb[$];
  exp_t sb16[$];
  int   vecs = 0;
  int   errs = 0;
  logic [31:0] m_hi, m_lo, m_hi16, m_lo16;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit operands.
  function automatic logic [63:0] ref_op(int w, logic [2:0] o,
      logic [31:0] x, logic [31:0] y,
      logic [31:0] ohi, logic [31:0] olo);
    logic [63:0] mask, ux, uy, p;
    longint      sx, sy, q, r;
    logic [31:0] rh, rl;
    mask = (64'd1 << w) - 64'd1;
    ux = {32'd0, x} & mask;
    uy = {32'd0, y} & mask;
    sx = x[w-1] ? longint'(ux) - (longint'(1) << w) : longint'(ux);
    sy = y[w-1] ? longint'(uy) - (longint'(1) << w) : longint'(uy);
    rh = ohi;
    rl = olo;
    case (o)
      3'd0: begin
        p  = sx * sy;
        rh = 32'((p >> w) & mask);
        rl = 32'(p & mask);
      end
      3'd1: begin
        p  = ux * uy;
        rh = 32'((p >> w) & mask);
        rl = 32'(p & mask);
      end
      3'd2: if (sy != 0) begin
        q  = sx / sy;
        r  = sx % sy;
        rl = 32'(q & mask);
        rh = 32'(r & mask);
      end
      3'd3: if (uy != 0) begin
        rl = 32'(ux / uy);
        rh = 32'(ux % uy);
      end
      3'd4: rh = 32'(ux);
      3'd5: rl = 32'(ux);
      default: ;
    endcase
    return {rh, rl};
  endfunction

  task automatic push_reset();
    exp_t e;
    e.hi = 0; e.lo = 0; e.lat = 0; e.rst = 1'b1;
    sb.delete();
    sb16.delete();
    sb.push_back(e);
    sb16.push_back(e);
    m_hi = 0; m_lo = 0; m_hi16 = 0; m_lo16 = 0;
  endtask

  // Called at a negedge; returns at the negedge before the earliest
  // next accept. poke issues an MTLO mid-op, abort asserts reset.
  task automatic issue(logic [2:0] o, logic [31:0] x, logic [31:0] y,
                       int poke, int abort);
    exp_t e;
    logic [63:0] r;
    r = ref_op(32, o, x, y, m_hi, m_lo);
    e.hi = r[63:32]; e.lo = r[31:0]; e.rst = 1'b0;
    e.lat = (o < 3'd2) ? 5 : (o < 3'd4) ? 10 : 0;
    sb.push_back(e);
    m_hi = e.hi; m_lo = e.lo;
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
    for (int j = 1; j <= e.lat; j++) begin
      if (j == poke) begin
        op = 3'd5; a = 32'h55; start = 1'b1;
      end
      if (j == abort) begin
        reset = 1'b1;
        push_reset();
      end
      @(negedge clk);
      start = 1'b0;
      reset = 1'b0;
    end
  endtask

  task automatic issue16(logic [2:0] o, logic [15:0] x, logic [15:0] y);
    exp_t e;
    logic [63:0] r;
    r = ref_op(16, o, {16'd0, x}, {16'd0, y}, m_hi16, m_lo16);
    e.hi = r[63:32]; e.lo = r[31:0]; e.rst = 1'b0;
    e.lat = (o < 3'd2) ? 1 : (o < 3'd4) ? 3 : 0;
    sb16.push_back(e);
    m_hi16 = e.hi; m_lo16 = e.lo;
    op16 = o; a16 = x; b16 = y; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    repeat (e.lat) @(negedge clk);
  endtask

  int          cnt = 0;
  logic [31:0] cur_hi = 0, cur_lo = 0;
  exp_t        me;

  always @(posedge clk) begin
    #1;
    if (busy) begin
      cnt++;
      chk("hold_hi", hi, cur_hi);
      chk("hold_lo", lo, cur_lo);
      if (cnt > 100) begin
        chk("busy_timeout", cnt, 0);
        cnt = 0;
        if (sb.size() != 0) void'(sb.pop_front());
      end
    end else if (sb.size() != 0) begin
      me = sb.pop_front();
      if (!me.rst) chk("busy_cycles", cnt, me.lat);
      chk("hi", hi, me.hi);
      chk("lo", lo, me.lo);
      cur_hi = me.hi;
      cur_lo = me.lo;
      cnt = 0;
    end else begin
      chk("spurious_busy", cnt, 0);
      chk("idle_hi", hi, cur_hi);
      chk("idle_lo", lo, cur_lo);
      cnt = 0;
    end
  end

  int          cnt16 = 0;
  logic [31:0] cur_hi16 = 0, cur_lo16 = 0;
  exp_t        me16;

  always @(posedge clk) begin
    #1;
    if (busy16) begin
      cnt16++;
      chk("w16_hold_hi", {16'd0, hi16}, cur_hi16);
      chk("w16_hold_lo", {16'd0, lo16}, cur_lo16);
      if (cnt16 > 100) begin
        chk("w16_busy_timeout", cnt16, 0);
        cnt16 = 0;
        if (sb16.size() != 0) void'(sb16.pop_front());
      end
    end else if (sb16.size() != 0) begin
      me16 = sb16.pop_front();
      if (!me16.rst) chk("w16_busy_cycles", cnt16, me16.lat);
      chk("w16_hi", {16'd0, hi16}, me16.hi);
      chk("w16_lo", {16'd0, lo16}, me16.lo);
      cur_hi16 = me16.hi;
      cur_lo16 = me16.lo;
      cnt16 = 0;
    end else begin
      chk("w16_spurious_busy", cnt16, 0);
      cnt16 = 0;
    end
  end

  initial begin
    logic [2:0]  ro;
    logic [31:0] rx, ry;
    reset = 1'b1; start = 1'b0; start16 = 1'b0;
    a = 0; b = 0; op = 0; a16 = 0; b16 = 0; op16 = 0;
    push_reset();
    @(negedge clk);
    reset = 1'b0;

    issue(3'd4, 32'h12345678, 32'h0, 0, 0);
    issue(3'd0, 32'hFFFFFFFE, 32'd3, 0, 0);
    issue(3'd1, 32'hFFFFFFFE, 32'd3, 0, 0);
    issue(3'd2, 32'hFFFFFFF9, 32'd2, 0, 0);
    issue(3'd3, 32'd7, 32'd2, 0, 0);
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    issue(3'd4, 32'hAA, 32'h0, 0, 0);
    issue(3'd5, 32'hBB, 32'h0, 0, 0);
    issue(3'd3, 32'h1234, 32'h0, 0, 0);
    issue(3'd0, 32'h1234, 32'h100, 2, 0);
    issue(3'd6, 32'hDEAD, 32'hBEEF, 0, 0);
    issue(3'd7, 32'hDEAD, 32'hBEEF, 0, 0);
    issue(3'd2, 32'd1000, 32'd7, 0, 3);
    repeat (15) @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 7))
        0: ry = 0;
        1: ry = 32'hFFFFFFFF;
        2: rx = 32'h80000000;
        3: ry = 32'($urandom_range(1, 9));
        default: ;
      endcase
      issue(ro, rx, ry, 0, 0);
    end

    issue16(3'd1, 16'hFFFF, 16'hFFFF);
    issue16(3'd0, 16'hFFFF, 16'hFFFF);
    issue16(3'd2, 16'h8000, 16'hFFFF);
    for (int i = 0; i < 20; i++)
      issue16(3'($urandom_range(0, 7)), 16'($urandom),
              16'($urandom_range(0, 3) == 0 ? 0 : $urandom));

    repeat (5) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    chk("sb16_drained", sb16.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
